// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode 7-segment scan driver with a per-frame snapshot of the BCD time digits.
// Slot 0 is sec0 (rightmost) and slot 5 is hour1; each slot opens with a short all-anodes-off gap.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec0,
    input  logic [3:0] sec1,
    input  logic [3:0] min0,
    input  logic [3:0] min1,
    input  logic [3:0] hour0,
    input  logic [3:0] hour1,
    input  logic       blank_lz,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [2:0] LAST_SLOT = 3'd5;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    snap [6];

    logic       tick;
    logic       last_slot;
    logic       slot_blank;
    logic [3:0] digit;
    logic [6:0] digit_seg;
    logic       lz_blank;
    logic [5:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    assign tick      = (cnt == CNT_MAX);
    assign last_slot = (idx == LAST_SLOT);

    // With no gap configured the comparison would be constant, so drop it entirely.
    if (BLANK_CYC == 0) begin : g_no_gap
        assign slot_blank = 1'b0;
    end else begin : g_gap
        localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
        assign slot_blank = (cnt < CNT_BLANK);
    end

    always_comb begin
        digit = 4'h0;
        case (idx)
            3'd0:    digit = snap[0];
            3'd1:    digit = snap[1];
            3'd2:    digit = snap[2];
            3'd3:    digit = snap[3];
            3'd4:    digit = snap[4];
            3'd5:    digit = snap[5];
            default: digit = 4'h0;
        endcase
    end

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes simply show nothing.
    always_comb begin
        digit_seg = 7'h7F;
        case (digit)
            4'd0:    digit_seg = 7'h40;
            4'd1:    digit_seg = 7'h79;
            4'd2:    digit_seg = 7'h24;
            4'd3:    digit_seg = 7'h30;
            4'd4:    digit_seg = 7'h19;
            4'd5:    digit_seg = 7'h12;
            4'd6:    digit_seg = 7'h02;
            4'd7:    digit_seg = 7'h78;
            4'd8:    digit_seg = 7'h00;
            4'd9:    digit_seg = 7'h10;
            default: digit_seg = 7'h7F;
        endcase
    end

    always_comb begin
        lz_blank = last_slot && blank_lz && (digit == 4'h0);
        an_nxt   = '1;
        seg_nxt  = 7'h7F;
        dp_nxt   = 1'b1;
        if (!slot_blank) begin
            an_nxt = ~(6'b000001 << idx);
            if (!lz_blank) begin
                seg_nxt = digit_seg;
                dp_nxt  = ~((idx == 3'd2) || (idx == 3'd4));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                snap[i] <= '0;
            end
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            frame_start <= tick && last_slot;
            if (tick) begin
                idx <= last_slot ? 3'd0 : idx + 3'd1;
            end
            if (tick && last_slot) begin
                snap[0] <= sec0;
                snap[1] <= sec1;
                snap[2] <= min0;
                snap[3] <= min1;
                snap[4] <= hour0;
                snap[5] <= hour1;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a time-indexed display model checked every cycle against two
// instances (one-cycle gap and no gap), plus directed literal checks from the display rules.
module tb_seg7_scan_driver;

    localparam int unsigned D = 4;
    localparam int unsigned FRAME = 6 * D;
    localparam logic [14:0] RST_OUT = {1'b0, 6'h3F, 7'h7F, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dig [6];
    logic       blank_lz;

    logic [5:0] an, an0;
    logic [6:0] seg, seg0;
    logic       dp, dp0, frame_start, fs0;

    int n_checks = 0;
    int n_fail = 0;

    int unsigned t;
    logic [3:0]  snap [6];

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(D), .BLANK_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .sec0(dig[0]), .sec1(dig[1]), .min0(dig[2]), .min1(dig[3]), .hour0(dig[4]), .hour1(dig[5]),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    seg7_scan_driver #(.SCAN_DIV(D), .BLANK_CYC(0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .sec0(dig[0]), .sec1(dig[1]), .min0(dig[2]), .min1(dig[3]), .hour0(dig[4]), .hour1(dig[5]),
        .blank_lz(blank_lz), .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
    );

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Outputs registered at the edge whose pre-edge position is tt cycles after reset release.
    function automatic logic [14:0] model(input int unsigned tt, input int unsigned gap, input logic lz);
        int unsigned c = tt % D;
        int unsigned s = (tt / D) % 6;
        logic [5:0] one = 6'b000001;
        logic       fs = (c == D - 1) && (s == 5);
        logic [5:0] ea = '1;
        logic [6:0] es = 7'h7F;
        logic       ed = 1'b1;
        if (c >= gap) begin
            ea = ~(one << s);
            if (!(s == 5 && lz && snap[5] == 4'h0)) begin
                es = decode(snap[s]);
                ed = !(s == 2 || s == 4);
            end
        end
        return {fs, ea, es, ed};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        logic [14:0] e1, e0;
        @(posedge clk);
        if (!rst_n) begin
            t = 0;
            for (int i = 0; i < 6; i++) snap[i] = 4'h0;
            e1 = RST_OUT;
            e0 = RST_OUT;
        end else begin
            e1 = model(t, 1, blank_lz);
            e0 = model(t, 0, blank_lz);
            if (t % FRAME == FRAME - 1)
                for (int i = 0; i < 6; i++) snap[i] = dig[i];
            t++;
        end
        #1;
        chk("dut_gap1", {17'd0, frame_start, an, seg, dp}, {17'd0, e1});
        chk("dut_gap0", {17'd0, fs0, an0, seg0, dp0}, {17'd0, e0});
    endtask

    task automatic wait_fs();
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            got = frame_start;
        end
        chk("wait_frame_start", {31'd0, got}, 32'd1);
    endtask

    // Advance to the first active (post-gap) output cycle of slot s.
    task automatic run_to_active(input int unsigned s);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            got = rst_n && ((t - 1) % FRAME == D * s + 1);
        end
        chk("reach_slot", {31'd0, got}, 32'd1);
    endtask

    task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0);
        dig[5] = h1; dig[4] = h0; dig[3] = m1; dig[2] = m0; dig[1] = s1; dig[0] = s0;
    endtask

    initial begin
        logic [6:0] lit [6];
        logic [5:0] one;
        int off1, off0, nfs;
        lit[0] = 7'h02; lit[1] = 7'h12; lit[2] = 7'h19;
        lit[3] = 7'h30; lit[4] = 7'h24; lit[5] = 7'h79;
        one = 6'b000001;
        t = 0;
        for (int i = 0; i < 6; i++) snap[i] = 4'h0;
        rst_n = 1'b0;
        blank_lz = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_gap_an", {26'd0, an}, 32'h3F);
        step();
        chk("post_reset_first_an", {26'd0, an}, 32'h3E);
        chk("post_reset_first_seg", {25'd0, seg}, 32'h40);

        // 12:34:56 captured at the first frame_start, shown in the following frame
        wait_fs();
        for (int unsigned s = 0; s < 6; s++) begin
            run_to_active(s);
            chk("frame_seg", {25'd0, seg}, {25'd0, lit[s]});
            chk("frame_an", {26'd0, an}, {26'd0, ~(one << s)});
            chk("frame_dp", {31'd0, dp}, {31'd0, !(s == 2 || s == 4)});
        end

        nfs = 0; off1 = 0; off0 = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_start) nfs++;
            if (an == 6'h3F && seg == 7'h7F) off1++;
            if (an0 == 6'h3F) off0++;
        end
        chk("frame_start_count", nfs, 2);
        chk("gap_cycles_b1", off1, 12);
        chk("gap_cycles_b0", off0, 0);

        // No tearing when the counter wraps mid-frame
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        wait_fs();
        run_to_active(3);
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        run_to_active(4);
        chk("tear_hour0", {25'd0, seg}, 32'h30);
        run_to_active(5);
        chk("tear_hour1", {25'd0, seg}, 32'h24);
        run_to_active(0);
        chk("new_frame_sec0", {25'd0, seg}, 32'h40);

        // Leading-zero blank, blank_lz sampled live
        set_time(4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0);
        blank_lz = 1'b1;
        wait_fs();
        run_to_active(5);
        chk("lz_an", {26'd0, an}, 32'h1F);
        chk("lz_seg", {25'd0, seg}, 32'h7F);
        blank_lz = 1'b0;
        step();
        chk("lz_off_seg", {25'd0, seg}, 32'h40);

        // Non-BCD digit blanks segments but keeps the anode
        dig[0] = 4'hC;
        wait_fs();
        run_to_active(0);
        chk("bad_bcd_seg", {25'd0, seg}, 32'h7F);
        chk("bad_bcd_an", {26'd0, an}, 32'h3E);

        // Asynchronous reset in the middle of slot 2
        run_to_active(2);
        chk("pre_reset_an", {26'd0, an}, 32'h3B);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_b1", {17'd0, frame_start, an, seg, dp}, {17'd0, RST_OUT});
        chk("async_rst_b0", {17'd0, fs0, an0, seg0, dp0}, {17'd0, RST_OUT});
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("restart_an", {26'd0, an}, 32'h3E);
        chk("restart_seg", {25'd0, seg}, 32'h40);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else begin
                if ($urandom_range(7) == 0) begin
                    for (int k = 0; k < 6; k++)
                        dig[k] = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
                end
                if ($urandom_range(3) == 0) dig[5] = 4'h0;
                if ($urandom_range(9) == 0) blank_lz = ~blank_lz;
                if ($urandom_range(499) == 0) #2 rst_n = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
